ghost_scheduler: RTL and testbench

Global sequencer for the four ghost movers.
- Releases ghosts from the pen in a fixed staggered order.
- Alternates the scatter/chase mode timer.
- Runs the frightened (power-pellet) period and ghost-eaten bookkeeping.
- Sits between the game-control logic and the ghost_* motion blocks; its outputs drive their per-ghost enable and targeting mode.

---
 rtl/ghost_scheduler.sv | 163 ++++++++++++++++
 tb/tb_ghost_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ghost_scheduler.sv
// Ghost scheduler: global sequencer for the ghost movers.
// Handles staggered pen release, the scatter/chase phase timer,
// the frightened period and eaten-ghost bookkeeping.
//
// state  | meaning
// S_IDLE | waiting for start_game, nothing counts
// S_RUN  | game in progress; start_game=0 pauses everything
// S_OVER | game over, outputs frozen until Reset
module ghost_scheduler #(
    parameter int NUM_GHOSTS     = 4,
    parameter int CNT_W          = 11,
    parameter int RELEASE_GAP    = 120,
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200,
    parameter int NUM_SCATTER    = 4,
    parameter int FRIGHT_FRAMES  = 360,
    parameter int FLASH_FRAMES   = 120
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    start_game,
    input  logic                    game_over,
    input  logic                    power_pellet,
    input  logic [NUM_GHOSTS-1:0]   ghost_eaten,
    input  logic [NUM_GHOSTS-1:0]   ghost_home,
    output logic [2*NUM_GHOSTS-1:0] ghost_state,
    output logic                    global_chase,
    output logic                    fright_flash,
    output logic                    eat_valid,
    output logic [1:0]              eat_combo
);

    localparam int PI_W = $clog2(2*NUM_SCATTER) + 1;
    localparam logic [PI_W-1:0]  PHASE_LAST   = PI_W'(2*NUM_SCATTER - 1);
    localparam logic [CNT_W-1:0] REL_MAX      = CNT_W'((NUM_GHOSTS-1)*RELEASE_GAP);
    localparam logic [CNT_W-1:0] SCATTER_LAST = CNT_W'(SCATTER_FRAMES - 1);
    localparam logic [CNT_W-1:0] CHASE_LAST   = CNT_W'(CHASE_FRAMES - 1);
    localparam logic [CNT_W-1:0] FRIGHT_LOAD  = CNT_W'(FRIGHT_FRAMES);
    localparam logic [CNT_W-1:0] FLASH_LIM    = CNT_W'(FLASH_FRAMES);

    localparam logic [1:0] G_PEN    = 2'b00;
    localparam logic [1:0] G_ACTIVE = 2'b01;
    localparam logic [1:0] G_FRIGHT = 2'b10;
    localparam logic [1:0] G_EATEN  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} top_t;

    top_t state, state_nxt;
    logic run_frame;

    logic [CNT_W-1:0] release_cnt, phase_cnt, fright_cnt;
    logic [CNT_W-1:0] release_nxt, phase_cnt_nxt, fright_nxt, phase_lim;
    logic [PI_W-1:0]  phase_idx, phase_idx_nxt;
    logic [1:0]       combo, combo_nxt;

    logic [NUM_GHOSTS-1:0]   fright_eat, eat_sel;
    logic                    eat_hit, fright_expire;
    logic [2*NUM_GHOSTS-1:0] ghost_nxt;

    // Top FSM state register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Top FSM next-state: game_over wins from anywhere, OVER is sticky
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (game_over) state_nxt = S_OVER;
                     else if (start_game) state_nxt = S_RUN;
            S_RUN:   if (game_over) state_nxt = S_OVER;
            default: state_nxt = S_OVER;
        endcase
    end

    // Top FSM output: the IDLE->RUN edge already counts as the first running frame
    always_comb begin
        run_frame = start_game && !game_over && (state != S_OVER);
    end

    // Eat arbitration: lowest-index frightened ghost wins; a pellet cancels the eat
    always_comb begin
        fright_eat = '0;
        for (int i = 0; i < NUM_GHOSTS; i++)
            fright_eat[i] = ghost_eaten[i] && (ghost_state[2*i +: 2] == G_FRIGHT);
        if (power_pellet) fright_eat = '0;
        eat_sel       = fright_eat & (~fright_eat + NUM_GHOSTS'(1));
        eat_hit       = |fright_eat;
        fright_expire = (fright_cnt == CNT_W'(1)) && !power_pellet;
    end

    // Per-ghost next state
    always_comb begin
        ghost_nxt = ghost_state;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            case (ghost_state[2*i +: 2])
                G_PEN:    if (release_cnt == CNT_W'(i*RELEASE_GAP)) ghost_nxt[2*i +: 2] = G_ACTIVE;
                G_ACTIVE: if (power_pellet) ghost_nxt[2*i +: 2] = G_FRIGHT;
                G_FRIGHT: if (power_pellet)      ghost_nxt[2*i +: 2] = G_FRIGHT;
                          else if (eat_sel[i])   ghost_nxt[2*i +: 2] = G_EATEN;
                          else if (fright_expire) ghost_nxt[2*i +: 2] = G_ACTIVE;
                default:  if (ghost_home[i]) ghost_nxt[2*i +: 2] = G_ACTIVE;
            endcase
        end
    end

    // Timer and combo next values; phase timer stalls during fright and after the last scatter
    always_comb begin
        release_nxt   = (release_cnt < REL_MAX) ? release_cnt + CNT_W'(1) : release_cnt;
        phase_lim     = phase_idx[0] ? CHASE_LAST : SCATTER_LAST;
        phase_cnt_nxt = phase_cnt;
        phase_idx_nxt = phase_idx;
        if (fright_cnt == '0 && phase_idx != PHASE_LAST) begin
            if (phase_cnt == phase_lim) begin
                phase_cnt_nxt = '0;
                phase_idx_nxt = phase_idx + PI_W'(1);
            end else begin
                phase_cnt_nxt = phase_cnt + CNT_W'(1);
            end
        end
        fright_nxt = fright_cnt;
        combo_nxt  = combo;
        if (power_pellet) begin
            fright_nxt = FRIGHT_LOAD;
            combo_nxt  = 2'd0;
        end else begin
            if (fright_cnt != '0) fright_nxt = fright_cnt - CNT_W'(1);
            if (eat_hit && combo != 2'd3) combo_nxt = combo + 2'd1;
        end
    end

    // Registered state and outputs; only running frames advance anything
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            ghost_state  <= '0;
            release_cnt  <= '0;
            phase_cnt    <= '0;
            phase_idx    <= '0;
            fright_cnt   <= '0;
            combo        <= 2'd0;
            fright_flash <= 1'b0;
            eat_valid    <= 1'b0;
            eat_combo    <= 2'd0;
        end else begin
            eat_valid <= 1'b0;
            if (run_frame) begin
                ghost_state  <= ghost_nxt;
                release_cnt  <= release_nxt;
                phase_cnt    <= phase_cnt_nxt;
                phase_idx    <= phase_idx_nxt;
                fright_cnt   <= fright_nxt;
                combo        <= combo_nxt;
                fright_flash <= (fright_nxt != '0) && (fright_nxt <= FLASH_LIM);
                eat_valid    <= eat_hit;
                if (eat_hit) eat_combo <= combo;
            end
        end
    end

    assign global_chase = phase_idx[0];

endmodule

// File: tb/tb_ghost_scheduler.sv
// Directed bench for ghost_scheduler. Frame index e = number of the most
// recent active edge since start (first edge is frame 0); outputs are
// sampled 1ns after that edge.
module tb_ghost_scheduler;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       start_game, game_over, power_pellet;
    logic [3:0] ghost_eaten, ghost_home;
    logic [7:0] ghost_state;
    logic       global_chase, fright_flash, eat_valid;
    logic [1:0] eat_combo;

    int n_cmp = 0;
    int n_bad = 0;
    int e     = -1;

    ghost_scheduler dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .start_game   (start_game),
        .game_over    (game_over),
        .power_pellet (power_pellet),
        .ghost_eaten  (ghost_eaten),
        .ghost_home   (ghost_home),
        .ghost_state  (ghost_state),
        .global_chase (global_chase),
        .fright_flash (fright_flash),
        .eat_valid    (eat_valid),
        .eat_combo    (eat_combo)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s (frame %0d): got %0h expected %0h", tag, e, obs, exp_v);
        end
    endtask

    task automatic frame();
        @(posedge frame_clk);
        #1;
        e++;
    endtask

    task automatic adv_to(input int target);
        while (e < target) frame();
    endtask

    // Apply a one-frame pulse on the edge numbered `target`
    task automatic pulse_at(input int target, input logic pp, input logic [3:0] eat, input logic [3:0] home);
        adv_to(target - 1);
        power_pellet = pp;
        ghost_eaten  = eat;
        ghost_home   = home;
        frame();
        power_pellet = 1'b0;
        ghost_eaten  = 4'b0;
        ghost_home   = 4'b0;
    endtask

    initial begin
        Reset = 1'b1; start_game = 1'b0; game_over = 1'b0;
        power_pellet = 1'b0; ghost_eaten = 4'b0; ghost_home = 4'b0;
        #12;
        chk("rst_state", ghost_state, 8'h00);
        chk("rst_chase", global_chase, 0);
        chk("rst_flash", fright_flash, 0);
        chk("rst_eat",   {eat_valid, eat_combo}, 0);
        @(posedge frame_clk); #1;
        Reset = 1'b0; start_game = 1'b1;

        // release stagger
        adv_to(0);   chk("rel_g0",     ghost_state, 8'h01);
        adv_to(119); chk("rel_g1_pre", ghost_state, 8'h01);
        adv_to(120); chk("rel_g1",     ghost_state, 8'h05);
        adv_to(240); chk("rel_g2",     ghost_state, 8'h15);
        adv_to(360); chk("rel_g3",     ghost_state, 8'h55);
        adv_to(418); chk("chase_pre",  global_chase, 0);
        adv_to(419); chk("chase_rise", global_chase, 1);

        // fright, eats, return, expiry
        pulse_at(500, 1'b1, 4'b0000, 4'b0000);
        chk("fright_all", ghost_state, 8'hAA);
        chk("fright_noflash", fright_flash, 0);
        pulse_at(510, 1'b0, 4'b0110, 4'b0000);
        chk("eat1_state", ghost_state, 8'hAE);
        chk("eat1_pulse", {eat_valid, eat_combo}, {1'b1, 2'd0});
        pulse_at(511, 1'b0, 4'b0100, 4'b0000);
        chk("eat2_state", ghost_state, 8'hBE);
        chk("eat2_pulse", {eat_valid, eat_combo}, {1'b1, 2'd1});
        frame();
        chk("eat_pulse_end", eat_valid, 0);
        pulse_at(520, 1'b0, 4'b0000, 4'b0010);
        chk("home_g1", ghost_state, 8'hB6);
        adv_to(739); chk("flash_pre",  fright_flash, 0);
        adv_to(740); chk("flash_rise", fright_flash, 1);
        adv_to(859); chk("expire_pre", ghost_state, 8'hB6);
        chk("flash_last", fright_flash, 1);
        adv_to(860); chk("expire", ghost_state, 8'h75);
        chk("flash_fall", fright_flash, 0);
        pulse_at(870, 1'b0, 4'b0000, 4'b0100);
        chk("home_g2", ghost_state, 8'h55);
        adv_to(1978); chk("chase_hold_delay", global_chase, 1);
        adv_to(1979); chk("chase_fall_delay", global_chase, 0);

        // pellet beats eat, combo restart, home during fright, reload
        pulse_at(2000, 1'b1, 4'b0001, 4'b0000);
        chk("pp_beats_eat", eat_valid, 0);
        chk("pp_beats_eat_st", ghost_state, 8'hAA);
        pulse_at(2010, 1'b0, 4'b1000, 4'b0000);
        chk("combo_clear", {eat_valid, eat_combo}, {1'b1, 2'd0});
        chk("eat_g3", ghost_state, 8'hEA);
        adv_to(2099); chk("reload_pre_flash", fright_flash, 0);
        pulse_at(2100, 1'b1, 4'b0000, 4'b0000);
        chk("reload_eaten_kept", ghost_state, 8'hEA);
        pulse_at(2110, 1'b0, 4'b0000, 4'b1000);
        chk("home_active_in_fright", ghost_state, 8'h6A);
        adv_to(2339); chk("reload_flash_pre", fright_flash, 0);
        adv_to(2340); chk("reload_flash", fright_flash, 1);
        adv_to(2459); chk("reload_hold", ghost_state, 8'h6A);
        adv_to(2460); chk("reload_expire", ghost_state, 8'h55);
        adv_to(2858); chk("chase2_pre",  global_chase, 0);
        adv_to(2859); chk("chase2_rise", global_chase, 1);
        adv_to(4059); chk("scat3_start", global_chase, 0);

        // pause mid-scatter, pellet ignored while paused
        adv_to(4100);
        start_game = 1'b0;
        pulse_at(4120, 1'b1, 4'b0000, 4'b0000);
        adv_to(4150);
        chk("pause_state", ghost_state, 8'h55);
        chk("pause_flash", fright_flash, 0);
        chk("pause_chase", global_chase, 0);
        start_game = 1'b1;
        adv_to(4528); chk("resume_pre",  global_chase, 0);
        adv_to(4529); chk("resume_rise", global_chase, 1);
        adv_to(5729); chk("scat4_start", global_chase, 0);
        adv_to(6148); chk("perm_pre",    global_chase, 0);
        adv_to(6149); chk("perm_rise",   global_chase, 1);
        adv_to(7400); chk("perm_hold",   global_chase, 1);

        // game over freeze
        pulse_at(7410, 1'b1, 4'b0000, 4'b0000);
        pulse_at(7411, 1'b0, 4'b0001, 4'b0000);
        chk("pre_over_eat", {eat_valid, eat_combo}, {1'b1, 2'd0});
        chk("pre_over_st", ghost_state, 8'hAB);
        game_over = 1'b1;
        pulse_at(7412, 1'b0, 4'b0010, 4'b0000);
        chk("over_eat0", eat_valid, 0);
        chk("over_state", ghost_state, 8'hAB);
        adv_to(7812);
        chk("over_hold_st",    ghost_state, 8'hAB);
        chk("over_hold_chase", global_chase, 1);
        chk("over_hold_flash", fright_flash, 0);
        game_over = 1'b0;
        adv_to(7830);
        chk("over_sticky", ghost_state, 8'hAB);
        chk("over_sticky_combo", eat_combo, 2'd0);

        // async reset mid-game, IDLE waits for start
        start_game = 1'b0;
        Reset = 1'b1;
        #1;
        chk("async_rst_st",    ghost_state, 8'h00);
        chk("async_rst_chase", global_chase, 0);
        Reset = 1'b0;
        frame(); frame(); frame();
        chk("idle_hold", ghost_state, 8'h00);
        start_game = 1'b1;
        frame();
        chk("restart_g0", ghost_state, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
